// File: rtl/stat_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stat_arb_pkg
// Brief    : Shared encodings for the statistics read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package stat_arb_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;
    localparam logic [1:0] c_ST_CLR  = 2'd3;

    localparam logic [1:0] c_CNT_BYTE  = 2'd0;
    localparam logic [1:0] c_CNT_FRAME = 2'd1;
    localparam logic [1:0] c_CNT_DROP  = 2'd2;
    localparam logic [1:0] c_CNT_STALL = 2'd3;

    localparam int c_STAT_LATENCY_DEFAULT = 6;

endpackage
`default_nettype wire

// File: rtl/stat_read_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter, one-hot grant; pointer moves past the winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stat_arb_pkg::*;
#(
    parameter int REQ_COUNT = 4,
    parameter int IDX_WIDTH = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_COUNT-1:0] req,
    input  logic                 advance,
    output logic [REQ_COUNT-1:0] grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    logic [IDX_WIDTH-1:0] r_ptr;
    logic [IDX_WIDTH-1:0] w_cand;

    // Search starts at the pointer, so the last winner has lowest priority.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_cand      = '0;
        for (int off = 0; off < REQ_COUNT; off++) begin
            w_cand = IDX_WIDTH'((int'(r_ptr) + off) % REQ_COUNT);
            if (!grant_valid && req[w_cand]) begin
                grant_valid    = 1'b1;
                grant[w_cand]  = 1'b1;
                grant_idx      = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && grant_valid) begin
            r_ptr <= (32'(grant_idx) == REQ_COUNT - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stat_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stat_read_arbiter
// Brief    : Shares one fixed-latency statistics reader among requesters.
//            Clear-after-read is built only with macro STAT_ARB_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stat_read_arbiter
    import stat_arb_pkg::*;
#(
    parameter int REQ_COUNT    = 4,
    parameter int PORT_COUNT   = 4,
    parameter int PORT_WIDTH   = $clog2(PORT_COUNT),
    parameter int STAT_LATENCY = c_STAT_LATENCY_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_COUNT-1:0]            req_valid,
    output logic [REQ_COUNT-1:0]            req_ready,
    input  logic [REQ_COUNT*PORT_WIDTH-1:0] req_port,
    input  logic [REQ_COUNT*2-1:0]          req_addr,
    input  logic [REQ_COUNT-1:0]            req_clr,
    output logic [REQ_COUNT-1:0]            resp_valid,
    output logic [31:0]                     resp_data,
    output logic [PORT_WIDTH-1:0]           port_select,
    output logic [1:0]                      stat_addr,
    input  logic [31:0]                     stat_data,
    output logic [PORT_COUNT-1:0]           port_clear,
    output logic                            busy
);

    localparam int c_IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int c_CNT_W = (STAT_LATENCY > 1) ? $clog2(STAT_LATENCY) : 1;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [PORT_WIDTH-1:0] r_port;
    logic [1:0]            r_addr;
    logic [c_IDX_W-1:0]    r_idx;
    logic [31:0]           r_captured;
    logic [REQ_COUNT-1:0]  r_resp_valid;
    logic [31:0]           r_resp_data;

    logic [REQ_COUNT-1:0]  w_grant;
    logic [c_IDX_W-1:0]    w_gidx;
    logic                  w_any;
    logic                  w_take;
    logic                  w_port_ok;
    logic                  w_clr_armed;
    logic [REQ_COUNT-1:0]  w_resp_sel;

    rr_arbiter #(
        .REQ_COUNT (REQ_COUNT),
        .IDX_WIDTH (c_IDX_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .advance     (w_take),
        .grant       (w_grant),
        .grant_idx   (w_gidx),
        .grant_valid (w_any)
    );

    assign w_take    = (r_state == c_ST_IDLE) && w_any;
    assign w_port_ok = (32'(r_port) < PORT_COUNT);

    // Ready is combinational so a withdrawn request never sees a stale grant.
    assign req_ready   = (rst_n && (r_state == c_ST_IDLE)) ? w_grant : '0;
    assign busy        = (r_state != c_ST_IDLE);
    assign port_select = r_port;
    assign stat_addr   = r_addr;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;

    for (genvar r = 0; r < REQ_COUNT; r++) begin : g_resp_sel
        assign w_resp_sel[r] = (32'(r_idx) == r);
    end

`ifdef STAT_ARB_CLEAR_EN
    logic                  r_clr;
    logic [PORT_COUNT-1:0] r_port_clear;
    logic [PORT_COUNT-1:0] w_clear_sel;

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_clear_sel
        assign w_clear_sel[p] = (32'(r_port) == p);
    end

    // Out-of-range ports never arm a clear.
    assign w_clr_armed = r_clr && w_port_ok;
    assign port_clear  = r_port_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr        <= 1'b0;
            r_port_clear <= '0;
        end else begin
            if (w_take) begin
                r_clr <= req_clr[w_gidx];
            end
            r_port_clear <= (r_state == c_ST_CLR) ? w_clear_sel : '0;
        end
    end
`else
    logic w_unused_clr;

    assign w_unused_clr = ^req_clr;
    assign w_clr_armed  = 1'b0;
    assign port_clear   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_port       <= '0;
            r_addr       <= '0;
            r_idx        <= '0;
            r_captured   <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_take) begin
                        r_port  <= req_port[int'(w_gidx)*PORT_WIDTH +: PORT_WIDTH];
                        r_addr  <= req_addr[int'(w_gidx)*2 +: 2];
                        r_idx   <= w_gidx;
                        r_cnt   <= c_CNT_W'(STAT_LATENCY - 1);
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_captured <= stat_data;
                        r_state    <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_resp_valid <= w_resp_sel;
                    r_resp_data  <= w_port_ok ? r_captured : 32'h0;
                    r_state      <= w_clr_armed ? c_ST_CLR : c_ST_IDLE;
                end
`ifdef STAT_ARB_CLEAR_EN
                c_ST_CLR: begin
                    r_state <= c_ST_IDLE;
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stat_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stat_read_arbiter
// Brief    : Directed self-checking bench for stat_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stat_read_arbiter;

    localparam int REQ_COUNT  = 4;
    localparam int PORT_COUNT = 4;
    localparam int PORT_WIDTH = 3;
    localparam int STAT_LAT   = 6;
`ifdef STAT_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic [REQ_COUNT-1:0]            req_valid;
    logic [REQ_COUNT-1:0]            req_ready;
    logic [REQ_COUNT*PORT_WIDTH-1:0] req_port;
    logic [REQ_COUNT*2-1:0]          req_addr;
    logic [REQ_COUNT-1:0]            req_clr;
    logic [REQ_COUNT-1:0]            resp_valid;
    logic [31:0]                     resp_data;
    logic [PORT_WIDTH-1:0]           port_select;
    logic [1:0]                      stat_addr;
    logic [31:0]                     stat_data;
    logic [PORT_COUNT-1:0]           port_clear;
    logic                            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stat_read_arbiter #(
        .REQ_COUNT    (REQ_COUNT),
        .PORT_COUNT   (PORT_COUNT),
        .PORT_WIDTH   (PORT_WIDTH),
        .STAT_LATENCY (STAT_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_port    (req_port),
        .req_addr    (req_addr),
        .req_clr     (req_clr),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .port_select (port_select),
        .stat_addr   (stat_addr),
        .stat_data   (stat_data),
        .port_clear  (port_clear),
        .busy        (busy)
    );

    function automatic logic [31:0] stat_fn(input logic [2:0] p, input logic [1:0] a);
        if (p == 3'd2 && a == 2'd1) return 32'h0000_1234;
        return 32'hC0DE_0000 | {21'd0, p, 6'd0, a};
    endfunction

    // Reader: data for a select becomes valid exactly STAT_LAT cycles later.
    logic [31:0] rd_pipe [STAT_LAT-1];
    always @(posedge clk) begin
        rd_pipe[0] <= stat_fn(port_select, stat_addr);
        for (int i = 1; i < STAT_LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign stat_data = rd_pipe[STAT_LAT-2];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) begin r = i; n++; end
        return (n == 1) ? r : 99;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [2:0] p, input logic [1:0] a, input logic c);
        req_valid[i]                        = v;
        req_port[i*PORT_WIDTH +: PORT_WIDTH] = p;
        req_addr[i*2 +: 2]                  = a;
        req_clr[i]                          = c;
    endtask

    // k counts negedges since the grant cycle.
    task automatic wait_resp(input int k0, output int lat, output logic [3:0] rv,
                             output logic [31:0] rd, output logic bz);
        lat = -1; rv = '0; rd = '0; bz = 1'b0;
        for (int k = k0; k <= 30; k++) begin
            @(negedge clk);
            if (resp_valid !== '0) begin
                lat = k; rv = resp_valid; rd = resp_data; bz = busy;
                break;
            end
        end
    endtask

    task automatic txn(input int i, input logic [2:0] p, input logic [1:0] a, input logic c,
                       output int lat, output logic [3:0] rv, output logic [31:0] rd, output logic bz);
        int g = 0;
        @(negedge clk);
        set_req(i, 1'b1, p, a, c);
        #1;
        while (req_ready[i] !== 1'b1 && g < 40) begin
            @(negedge clk); #1; g++;
        end
        check_value("grant_immediate", g, 0);
        @(negedge clk);
        set_req(i, 1'b0, p, a, c);
        wait_resp(2, lat, rv, rd, bz);
    endtask

    int          lat;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        bz;
    logic        seen;
    int          g_idx[$];
    int          g_cyc[$];
    int          r_idx_q[$];
    logic [31:0] r_dat_q[$];
    logic        gbusy;
    logic        drop;
    int          exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_port = '0; req_addr = '0; req_clr = '0;
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_req_ready",   req_ready,   0);
        check_value("rst_resp_valid",  resp_valid,  0);
        check_value("rst_resp_data",   resp_data,   0);
        check_value("rst_port_select", port_select, 0);
        check_value("rst_stat_addr",   stat_addr,   0);
        check_value("rst_port_clear",  port_clear,  0);
        check_value("rst_busy",        busy,        0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read: req 0, port 2, frame counter
        @(negedge clk);
        set_req(0, 1'b1, 3'd2, 2'd1, 1'b0);
        #1;
        check_value("t1_ready", req_ready, 4'b0001);
        @(negedge clk);
        set_req(0, 1'b0, 3'd2, 2'd1, 1'b0);
        check_value("t1_busy", busy, 1);
        check_value("t1_port_select", port_select, 2);
        check_value("t1_stat_addr", stat_addr, 1);
        wait_resp(2, lat, rv, rd, bz);
        check_value("t1_latency", lat, 8);
        check_value("t1_resp_valid", rv, 4'b0001);
        check_value("t1_resp_data", rd, 32'h0000_1234);
        @(negedge clk);
        check_value("t1_resp_pulse", resp_valid, 0);
        check_value("t1_data_hold", resp_data, 32'h0000_1234);
        check_value("t1_idle", busy, 0);

        // Reset during WAIT abandons the transaction
        @(negedge clk);
        set_req(1, 1'b1, 3'd1, 2'd2, 1'b1);
        #1;
        check_value("t2_ready", req_ready, 4'b0010);
        @(negedge clk);
        set_req(1, 1'b0, 3'd1, 2'd2, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("t2_rst_busy", busy, 0);
        check_value("t2_rst_port_select", port_select, 0);
        check_value("t2_rst_stat_addr", stat_addr, 0);
        check_value("t2_rst_resp_data", resp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (resp_valid !== '0 || port_clear !== '0) seen = 1'b1;
        end
        check_value("t2_abandoned", seen, 0);
        txn(3, 3'd1, 2'd0, 1'b0, lat, rv, rd, bz);
        check_value("t2_next_latency", lat, 8);
        check_value("t2_next_valid", rv, 4'b1000);
        check_value("t2_next_data", rd, stat_fn(3'd1, 2'd0));

        // All four requesters held valid: round-robin order and throughput
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), 2'(3 - i), 1'b0);
        gbusy = 1'b0; drop = 1'b0;
        for (int c = 0; c < 80 && r_idx_q.size() < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (drop) begin req_valid = '0; drop = 1'b0; end
            #1;
            if (req_ready !== '0) begin
                if (busy) gbusy = 1'b1;
                g_idx.push_back(oh_idx(req_ready));
                g_cyc.push_back(c);
                if (g_idx.size() == 5) drop = 1'b1;
            end
            if (resp_valid !== '0) begin
                r_idx_q.push_back(oh_idx(resp_valid));
                r_dat_q.push_back(resp_data);
            end
        end
        check_value("rr_grant_count", g_idx.size(), 5);
        check_value("rr_resp_count", r_idx_q.size(), 5);
        check_value("rr_grant_while_busy", gbusy, 0);
        for (int k = 0; k < 5; k++) begin
            check_value("rr_order", (k < g_idx.size()) ? g_idx[k] : -1, exp_order[k]);
            check_value("rr_resp_idx", (k < r_idx_q.size()) ? r_idx_q[k] : -1, exp_order[k]);
            check_value("rr_resp_data", (k < r_dat_q.size()) ? r_dat_q[k] : 32'hFFFF_FFFF,
                        stat_fn(3'(exp_order[k]), 2'(3 - exp_order[k])));
        end
        check_value("rr_spacing", (g_cyc.size() >= 2) ? g_cyc[1] - g_cyc[0] : -1, 8);

        // Request withdrawn before grant leaves pointer untouched
        @(negedge clk);
        set_req(3, 1'b1, 3'd0, 2'd1, 1'b0);
        #1;
        check_value("t4_grant3", req_ready, 4'b1000);
        @(negedge clk);
        set_req(3, 1'b0, 3'd0, 2'd1, 1'b0);
        set_req(1, 1'b1, 3'd2, 2'd2, 1'b0);
        #1;
        check_value("t4_no_grant_busy", req_ready, 0);
        repeat (3) @(negedge clk);
        set_req(1, 1'b0, 3'd2, 2'd2, 1'b0);
        wait_resp(5, lat, rv, rd, bz);
        check_value("t4_latency", lat, 8);
        check_value("t4_resp_valid", rv, 4'b1000);
        check_value("t4_resp_data", rd, stat_fn(3'd0, 2'd1));
        @(negedge clk);
        set_req(1, 1'b1, 3'd2, 2'd2, 1'b0);
        set_req(2, 1'b1, 3'd3, 2'd0, 1'b0);
        #1;
        check_value("t4_rr_after_drop", req_ready, 4'b0010);
        @(negedge clk);
        set_req(1, 1'b0, 3'd2, 2'd2, 1'b0);
        set_req(2, 1'b0, 3'd3, 2'd0, 1'b0);
        wait_resp(2, lat, rv, rd, bz);
        check_value("t4_resp1_valid", rv, 4'b0010);
        check_value("t4_resp1_data", rd, stat_fn(3'd2, 2'd2));

        // Out-of-range port: zero data, no clear, full latency
        txn(2, 3'd5, 2'd0, 1'b1, lat, rv, rd, bz);
        check_value("t5_latency", lat, 8);
        check_value("t5_resp_valid", rv, 4'b0100);
        check_value("t5_resp_data", rd, 0);
        check_value("t5_busy_at_resp", bz, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (port_clear !== '0) seen = 1'b1;
        end
        check_value("t5_no_clear", seen, 0);

        // Clear-after-read on port 3
        txn(1, 3'd3, 2'd3, 1'b1, lat, rv, rd, bz);
        check_value("t6_latency", lat, 8);
        check_value("t6_resp_valid", rv, 4'b0010);
        check_value("t6_resp_data", rd, stat_fn(3'd3, 2'd3));
        check_value("t6_busy_at_resp", bz, CLR_EN);
        @(negedge clk);
        check_value("t6_port_clear", port_clear, CLR_EN ? 4'b1000 : 4'b0000);
        check_value("t6_idle", busy, 0);
        @(negedge clk);
        check_value("t6_clear_pulse", port_clear, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
